// File: rtl/dds_pkg.sv
// Shared defaults, quadrant encoding and the quarter-wave table generator for the DDS sine generator.
package dds_pkg;

    localparam int PHASE_W_DEF   = 16;
    localparam int LUT_AW_DEF    = 6;
    localparam int DATA_W_DEF    = 8;
    localparam int AMP_W_DEF     = 8;
    localparam int FTW_RESET_DEF = 1024;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // Elaboration-time only: round(full_scale * sin(2*pi*(idx+0.5)/(4N))) via a Taylor series,
    // so table contents do not depend on tool support for $sin.
    function automatic int sine_rom_value(input int idx, input int lut_aw, input int data_w);
        real x;
        real term;
        real sum;
        real full_scale;
        x = 2.0 * 3.141592653589793 * (real'(idx) + 0.5) / (4.0 * real'(1 << lut_aw));
        sum  = x;
        term = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        full_scale = real'((1 << (data_w - 1)) - 1);
        return $rtoi(sum * full_scale + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Registered quarter-wave sine magnitude table, 2^LUT_AW entries of DATA_W-1 unsigned bits.
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-2:0] mag
);

    localparam int N = 1 << LUT_AW;

    logic [DATA_W-2:0] table_w [N];

    for (genvar i = 0; i < N; i++) begin : g_entry
        localparam int VAL = sine_rom_value(i, LUT_AW, DATA_W);
        assign table_w[i] = VAL[DATA_W-2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag <= '0;
        end else begin
            mag <= table_w[addr];
        end
    end

endmodule

// File: rtl/dds_sine_gen.sv
// Phase-accumulator sine generator: accumulate/address, ROM, sign/scale stages.
// Optional amplitude scaling on the output stage is enabled by defining DDS_AMP_SCALE_EN.
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W   = PHASE_W_DEF,
    parameter int LUT_AW    = LUT_AW_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int AMP_W     = AMP_W_DEF,
    parameter int FTW_RESET = FTW_RESET_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync_clr,
    input  logic               ftw_load,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [AMP_W-1:0]   amp,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    output logic               wrap
);

    localparam int AW = LUT_AW + 2;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw;
    logic               acc_carry;
    logic [PHASE_W:0]   acc_sum;
    logic [PHASE_W-1:0] phase;

    logic               s1_valid;
    logic               s1_wrap;
    logic [AW-1:0]      s1_addr;

    quadrant_t          s1_quad;
    logic [LUT_AW-1:0]  rom_addr;
    logic [DATA_W-2:0]  rom_mag;
    logic               s2_valid;
    logic               s2_wrap;
    logic               s2_neg;

    logic signed [DATA_W-1:0] mag_s;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] sample_out;

    assign acc_sum = {1'b0, acc} + {1'b0, ftw};
    assign phase   = acc + phase_off;

    // acc_carry remembers whether the accumulate that produced the current acc overflowed,
    // so the flag rides with the sample taken at that phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ftw       <= PHASE_W'(FTW_RESET);
            acc_carry <= 1'b0;
            s1_valid  <= 1'b0;
            s1_wrap   <= 1'b0;
            s1_addr   <= '0;
        end else begin
            if (ftw_load) begin
                ftw <= ftw_in;
            end
            if (sync_clr) begin
                acc       <= '0;
                acc_carry <= 1'b0;
                s1_valid  <= 1'b0;
                s1_wrap   <= 1'b0;
            end else if (en) begin
                acc       <= acc_sum[PHASE_W-1:0];
                acc_carry <= acc_sum[PHASE_W];
                s1_valid  <= 1'b1;
                s1_wrap   <= acc_carry;
                s1_addr   <= phase[PHASE_W-1 -: AW];
            end else begin
                s1_valid  <= 1'b0;
                s1_wrap   <= 1'b0;
            end
        end
    end

    always_comb begin
        s1_quad  = quadrant_t'(s1_addr[AW-1 -: 2]);
        rom_addr = s1_addr[LUT_AW-1:0];
        if (s1_quad == QUAD_1 || s1_quad == QUAD_3) begin
            rom_addr = ~s1_addr[LUT_AW-1:0];
        end
    end

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .mag  (rom_mag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_wrap  <= 1'b0;
            s2_neg   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_wrap  <= s1_valid & s1_wrap;
            s2_neg   <= s1_addr[AW-1];
        end
    end

    assign mag_s  = {1'b0, rom_mag};
    assign sample = s2_neg ? -mag_s : mag_s;

`ifdef DDS_AMP_SCALE_EN
    localparam int PW = DATA_W + AMP_W + 1;

    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] amp_ext;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] scaled;
    logic                 unused_bits;

    assign sample_ext  = PW'(sample);
    assign amp_ext     = PW'($signed({1'b0, amp}));
    assign product     = sample_ext * amp_ext;
    assign scaled      = product >>> AMP_W;
    assign sample_out  = scaled[DATA_W-1:0];
    assign unused_bits = ^{phase[PHASE_W-AW-1:0], scaled[PW-1:DATA_W]};
`else
    logic unused_bits;

    assign sample_out  = sample;
    assign unused_bits = ^{phase[PHASE_W-AW-1:0], amp};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            if (s2_valid) begin
                data_out <= sample_out;
            end
            data_valid <= s2_valid;
            wrap       <= s2_valid & s2_wrap;
        end
    end

endmodule

// File: tb/tb_dds_sine_gen.sv
// Self-checking bench for dds_sine_gen: directed scenarios plus randomized traffic against a sine model.
module tb_dds_sine_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync_clr;
    logic        ftw_load;
    logic [15:0] ftw_in;
    logic [15:0] phase_off;
    logic [7:0]  amp;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        wrap;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DDS_AMP_SCALE_EN
    localparam int PK = 63, TR = -64, SMALL = 1, NSMALL = -1;
`else
    localparam int PK = 127, TR = -127, SMALL = 2, NSMALL = -2;
`endif

    typedef struct {
        bit v;
        int p;
        bit w;
    } ent_t;

    ent_t q_pipe[$];
    int   m_acc;
    int   m_ftw;
    bit   m_carry;
    int   exp_data;
    int   exp_valid;
    int   exp_wrap;

    dds_sine_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync_clr   (sync_clr),
        .ftw_load   (ftw_load),
        .ftw_in     (ftw_in),
        .phase_off  (phase_off),
        .amp        (amp),
        .data_out   (data_out),
        .data_valid (data_valid),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Ideal full-circle sine at the centre of the 256-entry address bin, then optional scaling.
    function automatic int ref_sample(input int p);
        int  addr;
        real x;
        int  s;
        addr = p >> 8;
        x = 127.0 * $sin(2.0 * 3.141592653589793 * (real'(addr) + 0.5) / 256.0);
        s = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
`ifdef DDS_AMP_SCALE_EN
        s = (s * int'(amp)) >>> 8;
`endif
        return s;
    endfunction

    task automatic model_reset();
        q_pipe.delete();
        m_acc     = 0;
        m_ftw     = 1024;
        m_carry   = 1'b0;
        exp_data  = 0;
        exp_valid = 0;
        exp_wrap  = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        int   sum;
        e = '{v: 1'b0, p: 0, w: 1'b0};
        if (rst) begin
            model_reset();
            return;
        end
        if (sync_clr) begin
            m_acc   = 0;
            m_carry = 1'b0;
        end else if (en) begin
            e.v     = 1'b1;
            e.p     = (m_acc + int'(phase_off)) % 65536;
            e.w     = m_carry;
            sum     = m_acc + m_ftw;
            m_carry = (sum >= 65536);
            m_acc   = sum % 65536;
        end
        if (ftw_load) m_ftw = int'(ftw_in);
        q_pipe.push_back(e);
        exp_valid = 0;
        exp_wrap  = 0;
        if (q_pipe.size() >= 3) begin
            e = q_pipe.pop_front();
            if (e.v) begin
                exp_data  = ref_sample(e.p);
                exp_valid = 1;
                exp_wrap  = int'(e.w);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("data_out", $signed(data_out), exp_data);
        check_val("data_valid", int'(data_valid), exp_valid);
        check_val("wrap", int'(wrap), exp_wrap);
    endtask

    task automatic restart(input int new_ftw);
        sync_clr = 1'b1;
        ftw_load = 1'b1;
        ftw_in   = 16'(new_ftw);
        step();
        sync_clr = 1'b0;
        ftw_load = 1'b0;
    endtask

    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_data", $signed(data_out), 0);
        check_val("rst_valid", int'(data_valid), 0);
        check_val("rst_wrap", int'(wrap), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pat[4];
        int n_pk;
        int n_tr;

        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; ftw_load = 1'b0;
        ftw_in = '0; phase_off = '0; amp = 8'd128;
        model_reset();
        step();
        step();
        check_val("reset_data", $signed(data_out), 0);
        check_val("reset_valid", int'(data_valid), 0);
        rst = 1'b0;

        // ftw = 0: constant smallest positive sample
        restart(0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_val("ftw0_data", $signed(data_out), SMALL);
        check_val("ftw0_valid", int'(data_valid), 1);

        // quarter-cycle tuning word, wrap flag on each return to phase 0
        pat[0] = SMALL; pat[1] = PK; pat[2] = NSMALL; pat[3] = TR;
        restart(16384);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("q_seq", $signed(data_out), pat[k % 4]);
            check_val("q_wrap", int'(wrap), (k >= 4 && (k % 4) == 0) ? 1 : 0);
        end

        // 64-sample period: peak and trough each twice
        restart(1024);
        step();
        step();
        n_pk = 0;
        n_tr = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if ($signed(data_out) == 127) n_pk++;
            if ($signed(data_out) == -127) n_tr++;
        end
`ifndef DDS_AMP_SCALE_EN
        check_val("peak_count", n_pk, 2);
        check_val("trough_count", n_tr, 2);
`endif

        // phase offset to 90 degrees, then bubble latency with en low
        phase_off = 16'd16384;
        restart(0);
        for (int i = 0; i < 4; i++) step();
        check_val("off_data", $signed(data_out), PK);
        en = 1'b0;
        step();
        step();
        check_val("en_off_valid2", int'(data_valid), 1);
        step();
        check_val("en_off_valid3", int'(data_valid), 0);
        check_val("en_off_hold", $signed(data_out), PK);

        // mid-stream reset, then ftw back to its reset value
        en = 1'b1;
        restart(5000);
        for (int i = 0; i < 5; i++) step();
        pulse_reset();
        phase_off = '0;
        step();
        step();
        step();
        check_val("post_rst_first", $signed(data_out), SMALL);
        check_val("post_rst_valid", int'(data_valid), 1);
        step();
        check_val("post_rst_second", $signed(data_out), ref_sample(1024));

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            en       = ($urandom_range(0, 3) != 0);
            sync_clr = ($urandom_range(0, 19) == 0);
            ftw_load = ($urandom_range(0, 9) == 0);
            ftw_in   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) phase_off = 16'($urandom);
            if ($urandom_range(0, 15) == 0) amp = 8'($urandom);
            if (c == 300) pulse_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sine_gen.md
DDS_SINE_GEN -- requirements
Module: dds_sine_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 16: phase accumulator and tuning-word width.
REQ-002 SHALL have parameter LUT_AW, default 6: quarter-wave ROM address width, 2^LUT_AW entries.
REQ-003 SHALL have parameter DATA_W, default 8: signed sample width.
REQ-004 SHALL have parameter AMP_W, default 8: unsigned amplitude width.
REQ-005 SHALL have parameter FTW_RESET, default 1024: tuning word loaded at reset.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port en, input, 1: advance phase and issue one sample this cycle.
REQ-009 SHALL have port sync_clr, input, 1: synchronous phase clear.
REQ-010 SHALL have port ftw_load, input, 1: load strobe for ftw_in.
REQ-011 SHALL have port ftw_in, input, PHASE_W: new frequency tuning word.
REQ-012 SHALL have port phase_off, input, PHASE_W: phase offset, sampled every cycle.
REQ-013 SHALL have port amp, input, AMP_W: amplitude scale, value/2^AMP_W.
REQ-014 SHALL have port data_out, output, DATA_W: signed two's-complement sample.
REQ-015 SHALL have port data_valid, output, 1: data_out carries a new sample.
REQ-016 SHALL have port wrap, output, 1: sample is the first after an accumulator carry-out.

Function
REQ-017 On en=1 and sync_clr=0, acc SHALL become (acc+ftw) mod 2^PHASE_W, and acc+phase_off SHALL enter the pipeline.
REQ-018 The pipeline address SHALL be the top LUT_AW+2 bits of (acc+phase_off) mod 2^PHASE_W.
REQ-019 The top 2 bits (quadrant) SHALL select the sample: q0 rom[i]; q1 rom[N-1-i]; q2 -rom[i]; q3 -rom[N-1-i], with N=2^LUT_AW.
REQ-020 The ROM SHALL hold rom[i] = round((2^(DATA_W-1)-1) * sin(2*pi*(i+0.5)/(4N))).
REQ-021 The pipeline SHALL have 3 stages (address/accumulate, ROM register, sign/scale register); data_valid SHALL rise after the 3rd edge counting the en sampling edge.
REQ-022 With en=0, acc SHALL hold, a bubble SHALL enter the pipeline, and data_out SHALL hold its last value.
REQ-023 ftw_load=1 SHALL update ftw at the edge; an increment on that same edge SHALL use the old ftw.
REQ-024 sync_clr=1 SHALL set acc to 0 with priority over en, and no sample SHALL be issued that cycle.
REQ-025 sync_clr=1 together with ftw_load=1 SHALL apply both.
REQ-026 wrap SHALL travel with its sample and be 1 only when the accumulate producing that sample's phase carried out.
REQ-027 The phase SHALL wrap modulo 2^PHASE_W with no skipped or repeated address.

Reset
REQ-028 rst=1 SHALL immediately force acc=0, ftw=FTW_RESET, all pipeline valids=0, data_out=0, data_valid=0, wrap=0.
REQ-029 Reset mid-stream SHALL discard in-flight samples; the first sample after release SHALL be at phase phase_off.

Configuration
REQ-030 With DDS_AMP_SCALE_EN defined, stage 3 SHALL output (sample*amp) >>> AMP_W, arithmetic shift with floor rounding.
REQ-031 Without DDS_AMP_SCALE_EN, amp SHALL be ignored and stage 3 SHALL register the unscaled sample; latency SHALL be unchanged.

Structure
REQ-032 Package dds_pkg SHALL hold the default parameter constants and the quadrant enumeration.
REQ-033 The ROM SHALL be a sub-module sine_quarter_rom, registered-output and parameterised by LUT_AW and DATA_W.

Verification (defaults; macro off unless stated)
REQ-034 Release reset with ftw=0 and en=1 -> data_out stays 2 and data_valid=1 from the 3rd edge.
REQ-035 Load ftw 16384 with en=1 -> samples 2, 127, -2, -127 repeating; wrap=1 on every 2 after the first.
REQ-036 Load ftw=1024 -> period is exactly 64 samples, with peak 127 and trough -127 each seen twice per period.
REQ-037 phase_off=16384 with ftw=0 -> constant 127; toggling en -> data_valid drops 3 edges later and data_out holds.
REQ-038 Assert rst mid-stream -> outputs 0 immediately; after release with ftw back at 1024, the first sample is 2.
REQ-039 With DDS_AMP_SCALE_EN and amp=128, ftw=16384 -> samples 1, 63, -1, -64.
